// File: rtl/inst_encoder.sv
// Packs symbolic instruction descriptors into RV32I words and writes them
// sequentially into instruction memory over a write/ack interface.
module inst_encoder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_kind,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [12:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  input  logic                  mem_ack,
  output logic                  err,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  logic        last_addr;
  logic        wr_done;
  logic        accept;
  logic        legal;
  logic [31:0] enc;

  assign last_addr = (addr_q == '1);
  assign wr_done   = (state_q == ST_HOLD) && mem_ack;

  // A new descriptor may overlap the ack of the previous write, except when
  // that write fills the last address.
  assign in_ready = rst_n && (state_q != ST_FULL) && !clear &&
                    ((state_q == ST_IDLE) ||
                     ((state_q == ST_HOLD) && mem_ack && !last_addr));
  assign accept   = in_valid && in_ready;

  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (in_kind)
      3'd0: begin
        legal = (in_imm[12] == in_imm[11]);
        enc   = {in_imm[11:0], in_rs1, 3'b110, in_rd, 7'b0010011};
      end
      3'd1: begin
        legal = (in_imm[12] == in_imm[11]);
        enc   = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      end
      3'd2: begin
        legal = (in_imm[12] == in_imm[11]);
        enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      end
      3'd3: enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      3'd4: enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      3'd5, 3'd6: begin
        legal = !in_imm[0];
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 2'b00, in_kind[1],
                 in_imm[4:1], in_imm[11], 7'b1100011};
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_IDLE;
      addr_d  = BASE;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      if (wr_done) begin
        cnt_d = cnt_q + 1'b1;
        if (last_addr) begin
          state_d = ST_FULL;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      if (accept) begin
        if (legal) begin
          data_d  = enc;
          state_d = ST_HOLD;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_we     = (state_q == ST_HOLD);
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign err        = err_q;
  assign done       = (state_q == ST_FULL);
  assign word_count = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a 4-word memory (ADDR_WIDTH=2).
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [12:0] in_imm;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        err;
  logic        done;
  logic [2:0]  word_count;

  int n_assert = 0;
  int n_fail   = 0;

  inst_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack), .err(err), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one descriptor, wait (bounded) for in_ready, hold through the accepting edge.
  task automatic put(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [12:0] imm);
    int n;
    in_valid = 1'b1; in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic ack1();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_kind = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; mem_ack = 1'b0;
    #2;
    in_valid = 1'b1;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_addr",  {30'd0, mem_addr}, 32'd0);
    chk("rst_data",  mem_data, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_count", {29'd0, word_count}, 32'd0);
    in_valid = 1'b0;
    #10;
    rst_n = 1'b1;
    step();

    // Encoding checks, filling the whole 4-word memory.
    put(3'd0, 5'd5, 5'd0, 5'd0, 13'h1FFF);
    chk("ori_we",   {31'd0, mem_we}, 32'd1);
    chk("ori_data", mem_data, 32'hFFF06293);
    chk("ori_addr", {30'd0, mem_addr}, 32'd0);
    ack1();
    chk("ori_done_we", {31'd0, mem_we}, 32'd0);
    chk("ori_addr1",   {30'd0, mem_addr}, 32'd1);
    chk("ori_count",   {29'd0, word_count}, 32'd1);
    put(3'd1, 5'd5, 5'd1, 5'd0, 13'h1FFC);
    chk("lw_data", mem_data, 32'hFFC0A283);
    chk("lw_addr", {30'd0, mem_addr}, 32'd1);
    ack1();
    put(3'd3, 5'd3, 5'd1, 5'd2, 13'h0);
    chk("add_data", mem_data, 32'h002081B3);
    chk("add_addr", {30'd0, mem_addr}, 32'd2);
    ack1();
    put(3'd4, 5'd3, 5'd1, 5'd2, 13'h0);
    chk("sub_data", mem_data, 32'h402081B3);
    chk("sub_addr", {30'd0, mem_addr}, 32'd3);
    chk("sub_ready_noack", {31'd0, in_ready}, 32'd0);
    ack1();
    chk("full_done",  {31'd0, done}, 32'd1);
    chk("full_count", {29'd0, word_count}, 32'd4);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_kind = 3'd3;
    step(); step();
    chk("full_no_accept_we",    {31'd0, mem_we}, 32'd0);
    chk("full_no_accept_count", {29'd0, word_count}, 32'd4);
    chk("full_ready2",          {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    do_clear();
    chk("clr_done",  {31'd0, done}, 32'd0);
    chk("clr_count", {29'd0, word_count}, 32'd0);
    chk("clr_addr",  {30'd0, mem_addr}, 32'd0);

    // Store then branch back to back with ack tied high, then backpressure.
    mem_ack = 1'b1;
    put(3'd2, 5'd0, 5'd1, 5'd2, 13'h0008);
    chk("sw_data", mem_data, 32'h0020A423);
    chk("sw_addr", {30'd0, mem_addr}, 32'd0);
    put(3'd5, 5'd0, 5'd1, 5'd2, 13'h1FF8);
    mem_ack = 1'b0;
    chk("beq_we",    {31'd0, mem_we}, 32'd1);
    chk("beq_data",  mem_data, 32'hFE208CE3);
    chk("beq_addr",  {30'd0, mem_addr}, 32'd1);
    chk("beq_count", {29'd0, word_count}, 32'd1);
    in_valid = 1'b1; in_kind = 3'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_we",    {31'd0, mem_we}, 32'd1);
      chk("bp_addr",  {30'd0, mem_addr}, 32'd1);
      chk("bp_data",  mem_data, 32'hFE208CE3);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    ack1();
    chk("bp_done_we", {31'd0, mem_we}, 32'd0);
    chk("bp_addr2",   {30'd0, mem_addr}, 32'd2);
    chk("bp_count",   {29'd0, word_count}, 32'd2);

    // Illegal descriptors.
    chk("pre_ill_err", {31'd0, err}, 32'd0);
    put(3'd5, 5'd0, 5'd1, 5'd2, 13'h0003);
    chk("beq_odd_err",   {31'd0, err}, 32'd1);
    chk("beq_odd_we",    {31'd0, mem_we}, 32'd0);
    chk("beq_odd_addr",  {30'd0, mem_addr}, 32'd2);
    chk("beq_odd_count", {29'd0, word_count}, 32'd2);
    do_clear();
    chk("clr_err", {31'd0, err}, 32'd0);
    put(3'd1, 5'd5, 5'd1, 5'd0, 13'h0800);
    chk("lw_big_err",   {31'd0, err}, 32'd1);
    chk("lw_big_we",    {31'd0, mem_we}, 32'd0);
    chk("lw_big_count", {29'd0, word_count}, 32'd0);
    do_clear();
    put(3'd7, 5'd1, 5'd1, 5'd1, 13'h0);
    chk("kind7_err",  {31'd0, err}, 32'd1);
    chk("kind7_we",   {31'd0, mem_we}, 32'd0);
    chk("kind7_addr", {30'd0, mem_addr}, 32'd0);

    // Clear during HOLD with a simultaneous ack.
    put(3'd0, 5'd1, 5'd2, 5'd0, 13'h0001);
    chk("hold_we", {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b1;
    do_clear();
    mem_ack = 1'b0;
    chk("clrh_we",    {31'd0, mem_we}, 32'd0);
    chk("clrh_addr",  {30'd0, mem_addr}, 32'd0);
    chk("clrh_err",   {31'd0, err}, 32'd0);
    chk("clrh_count", {29'd0, word_count}, 32'd0);

    // Asynchronous reset mid-stream.
    put(3'd3, 5'd3, 5'd1, 5'd2, 13'h0);
    ack1();
    put(3'd4, 5'd3, 5'd1, 5'd2, 13'h0);
    chk("pre_rst_addr", {30'd0, mem_addr}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we",    {31'd0, mem_we}, 32'd0);
    chk("arst_addr",  {30'd0, mem_addr}, 32'd0);
    chk("arst_data",  mem_data, 32'd0);
    chk("arst_count", {29'd0, word_count}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
